// File: rtl/jtopl_rhy_phase_pkg.sv
// rtl/jtopl_rhy_phase_pkg.sv - shared slot-pipeline constants and types
// Purpose: slot-index type, rhythm slot positions, frame length and the
//          OR masks used to build the OPL2 rhythm phases.
// Ports:   none (package).
package jtopl_rhy_phase_pkg;

  typedef logic [4:0] slot_t;

  localparam int RHY_NSLOTS = 18;

  // Register-order operator slots carrying the rhythm instruments
  localparam int RHY_HH_SLOT = 13;   // ch7 op1, Hi-Hat
  localparam int RHY_TT_SLOT = 14;   // ch8 op1, Tom-Tom
  localparam int RHY_SD_SLOT = 16;   // ch7 op2, Snare Drum
  localparam int RHY_TC_SLOT = 17;   // ch8 op2, Top Cymbal

  localparam logic [9:0] RHY_MASK_HH_A = 10'h0D0;
  localparam logic [9:0] RHY_MASK_HH_B = 10'h034;
  localparam logic [9:0] RHY_MASK_TC   = 10'h080;

endpackage

// File: rtl/jtopl_rhy_phase_if.sv
// rtl/jtopl_rhy_phase_if.sv - slot-stream bus between phase generator and operator
// Purpose: bundles the per-slot stream into the rhythm phase stage.
// Signals: cen, zero, rhy_en, noise, phase_in (toward stage);
//          phase_out, rhy_slot (from stage).
interface jtopl_rhy_phase_if;

  logic       cen;
  logic       zero;
  logic       rhy_en;
  logic       noise;
  logic [9:0] phase_in;
  logic [9:0] phase_out;
  logic       rhy_slot;

  modport master (
    output cen, zero, rhy_en, noise, phase_in,
    input  phase_out, rhy_slot
  );

  modport slave (
    input  cen, zero, rhy_en, noise, phase_in,
    output phase_out, rhy_slot
  );

endinterface

// File: rtl/jtopl_slot_cnt.sv
// rtl/jtopl_slot_cnt.sv - operator slot counter with zero-pulse resync
// Purpose: tracks which slot is on the pipeline this cen cycle.
// Ports:   clk, rst (sync, active-high); i_cen clock enable; i_zero marks
//          slot 0; o_cur current slot index; o_synced set after first zero.
module jtopl_slot_cnt
  import jtopl_rhy_phase_pkg::*;
#(
  parameter int NSLOTS = RHY_NSLOTS
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_cen,
  input  logic  i_zero,
  output slot_t o_cur,
  output logic  o_synced
);

  slot_t r_cnt;
  logic  r_synced;
  slot_t w_cur;

  // zero overrides the count, so a misplaced zero realigns without notice
  assign w_cur = i_zero ? '0 : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_synced <= 1'b0;
    end else if (i_cen) begin
      r_cnt <= (w_cur == slot_t'(NSLOTS - 1)) ? '0 : w_cur + 5'd1;
      if (i_zero) r_synced <= 1'b1;
    end
  end

  assign o_cur    = w_cur;
  assign o_synced = r_synced;

endmodule

// File: rtl/jtopl_rhy_phase.sv
// rtl/jtopl_rhy_phase.sv - OPL2 rhythm-mode phase substitution for HH/SD/TC
// Purpose: replaces the phase of the Hi-Hat, Snare and Top-Cymbal slots with
//          the noise-modulated rhythm phase; other slots pass through.
// Ports:   clk, rst (sync, active-high); bus (slave): cen, zero, rhy_en,
//          noise, phase_in in; phase_out, rhy_slot out (1 cen latency).
module jtopl_rhy_phase
  import jtopl_rhy_phase_pkg::*;
#(
  parameter int HH_SLOT = RHY_HH_SLOT,
  parameter int SD_SLOT = RHY_SD_SLOT,
  parameter int TC_SLOT = RHY_TC_SLOT,
  parameter int NSLOTS  = RHY_NSLOTS
) (
  input  logic               clk,
  input  logic               rst,
  jtopl_rhy_phase_if.slave   bus
);

  slot_t w_cur;
  logic  w_synced;

  jtopl_slot_cnt #(.NSLOTS(NSLOTS)) u_slot_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_cen    (bus.cen),
    .i_zero   (bus.zero),
    .o_cur    (w_cur),
    .o_synced (w_synced)
  );

  logic w_is_hh, w_is_sd, w_is_tc;
  assign w_is_hh = (w_cur == slot_t'(HH_SLOT));
  assign w_is_sd = (w_cur == slot_t'(SD_SLOT));
  assign w_is_tc = (w_cur == slot_t'(TC_SLOT));

  // Phase bits latched from the HH and TC slots; refreshed even with
  // rhythm disabled so re-enabling starts from current values.
  logic r_hh2, r_hh3, r_hh7, r_hh8;
  logic r_tc3, r_tc5;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hh2 <= 1'b0;
      r_hh3 <= 1'b0;
      r_hh7 <= 1'b0;
      r_hh8 <= 1'b0;
      r_tc3 <= 1'b0;
      r_tc5 <= 1'b0;
    end else if (bus.cen) begin
      if (w_is_hh) begin
        r_hh2 <= bus.phase_in[2];
        r_hh3 <= bus.phase_in[3];
        r_hh7 <= bus.phase_in[7];
        r_hh8 <= bus.phase_in[8];
      end
      if (w_is_tc) begin
        r_tc3 <= bus.phase_in[3];
        r_tc5 <= bus.phase_in[5];
      end
    end
  end

  // Bypass: the slot that owns a bit group uses its live phase, the other
  // group comes from the latch (TC from last frame, HH from this frame).
  logic w_hh2, w_hh3, w_hh7, w_hh8, w_tc3, w_tc5;
  assign w_hh2 = w_is_hh ? bus.phase_in[2] : r_hh2;
  assign w_hh3 = w_is_hh ? bus.phase_in[3] : r_hh3;
  assign w_hh7 = w_is_hh ? bus.phase_in[7] : r_hh7;
  assign w_hh8 = w_is_hh ? bus.phase_in[8] : r_hh8;
  assign w_tc3 = w_is_tc ? bus.phase_in[3] : r_tc3;
  assign w_tc5 = w_is_tc ? bus.phase_in[5] : r_tc5;

  logic w_x;
  assign w_x = (w_hh2 ^ w_hh7) | (w_hh3 ^ w_tc5) | (w_tc3 ^ w_tc5);

  logic [9:0] w_next_phase;
  logic       w_next_rhy;

  always_comb begin
    w_next_phase = bus.phase_in;
    w_next_rhy   = 1'b0;
    if (bus.rhy_en && w_synced) begin
      if (w_is_hh) begin
        w_next_phase = {w_x, 9'b0} |
                       ((w_x ^ bus.noise) ? RHY_MASK_HH_A : RHY_MASK_HH_B);
        w_next_rhy   = 1'b1;
      end else if (w_is_sd) begin
        w_next_phase = {w_hh8, w_hh8 ^ bus.noise, 8'b0};
        w_next_rhy   = 1'b1;
      end else if (w_is_tc) begin
        w_next_phase = {w_x, 9'b0} | RHY_MASK_TC;
        w_next_rhy   = 1'b1;
      end
    end
  end

  logic [9:0] r_phase_out;
  logic       r_rhy_slot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase_out <= '0;
      r_rhy_slot  <= 1'b0;
    end else if (bus.cen) begin
      r_phase_out <= w_next_phase;
      r_rhy_slot  <= w_next_rhy;
    end
  end

  assign bus.phase_out = r_phase_out;
  assign bus.rhy_slot  = r_rhy_slot;

endmodule

// File: tb/tb_jtopl_rhy_phase.sv
// tb/tb_jtopl_rhy_phase.sv - self-checking bench for jtopl_rhy_phase
module tb_jtopl_rhy_phase;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtopl_rhy_phase_if bus ();

  jtopl_rhy_phase dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [9:0] ph;
    logic       rhy;
  } exp_t;

  typedef struct {
    logic       en;
    logic [9:0] hh_ph;
    logic       hh_n;
    logic       sd_n;
    logic [9:0] tc_ph;
    logic [9:0] e_hh;
    logic [9:0] e_sd;
    logic [9:0] e_tc;
  } frame_t;

  exp_t   q[$];
  frame_t ftab[12];
  int     n_cmp = 0;
  int     n_bad = 0;

  function automatic logic [9:0] other_ph(input int s);
    int v;
    v = (s * 37 + 11) & 10'h3FF;
    return v[9:0];
  endfunction

  task automatic check(input string nm, input int s, input logic [9:0] act,
                       input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s slot %0d: got %03h expected %03h", nm, s, act, exp);
    end
  endtask

  task automatic drive_slot(input logic z, input logic [9:0] ph, input logic en,
                            input logic nz, input logic [9:0] eph,
                            input logic erhy, input int tag);
    exp_t e;
    bus.cen      = 1'b1;
    bus.zero     = z;
    bus.phase_in = ph;
    bus.rhy_en   = en;
    bus.noise    = nz;
    q.push_back('{eph, erhy});
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard empty slot %0d", tag);
    end else begin
      e = q.pop_front();
      check("phase_out", tag, bus.phase_out, e.ph);
      check("rhy_slot", tag, {9'b0, bus.rhy_slot}, {9'b0, e.rhy});
    end
  endtask

  task automatic run_part(input frame_t f, input int first, input int last);
    logic [9:0] ph, eph;
    logic       nz, erhy;
    int         r;
    for (int s = first; s <= last; s++) begin
      r    = $urandom;
      nz   = r[0];
      erhy = 1'b0;
      if (s == 13) begin
        ph = f.hh_ph; nz = f.hh_n;
        eph = f.en ? f.e_hh : ph; erhy = f.en;
      end else if (s == 16) begin
        ph = 10'h3A5; nz = f.sd_n;
        eph = f.en ? f.e_sd : ph; erhy = f.en;
      end else if (s == 17) begin
        ph = f.tc_ph;
        eph = f.en ? f.e_tc : ph; erhy = f.en;
      end else begin
        ph = other_ph(s); eph = ph;
      end
      drive_slot(s == 0, ph, f.en, nz, eph, erhy, s);
    end
  endtask

  initial begin
    int r;
    logic [9:0] ph;

    //            en    hh_ph   hh_n  sd_n  tc_ph   e_hh    e_sd    e_tc
    ftab[0]  = '{1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 10'h2D0, 10'h000, 10'h280};
    ftab[1]  = '{1'b1, 10'h004, 1'b1, 1'b1, 10'h000, 10'h234, 10'h100, 10'h280};
    ftab[2]  = '{1'b1, 10'h100, 1'b0, 1'b1, 10'h000, 10'h034, 10'h200, 10'h080};
    ftab[3]  = '{1'b1, 10'h100, 1'b0, 1'b0, 10'h000, 10'h034, 10'h300, 10'h080};
    ftab[4]  = '{1'b1, 10'h000, 1'b0, 1'b0, 10'h020, 10'h034, 10'h000, 10'h280};
    ftab[5]  = '{1'b1, 10'h000, 1'b0, 1'b0, 10'h028, 10'h2D0, 10'h000, 10'h280};
    ftab[6]  = '{1'b1, 10'h000, 1'b1, 1'b1, 10'h000, 10'h234, 10'h100, 10'h080};
    ftab[7]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h020, 10'h000, 10'h000, 10'h000};
    ftab[8]  = '{1'b1, 10'h000, 1'b0, 1'b0, 10'h028, 10'h2D0, 10'h000, 10'h280};
    ftab[9]  = '{1'b1, 10'h000, 1'b0, 1'b1, 10'h000, 10'h034, 10'h100, 10'h080};
    ftab[10] = '{1'b1, 10'h004, 1'b0, 1'b0, 10'h000, 10'h2D0, 10'h000, 10'h280};
    ftab[11] = '{1'b1, 10'h100, 1'b1, 1'b1, 10'h000, 10'h0D0, 10'h200, 10'h080};

    bus.cen = 1'b0; bus.zero = 1'b0; bus.rhy_en = 1'b0;
    bus.noise = 1'b0; bus.phase_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_phase", -1, bus.phase_out, 10'h000);
    check("reset_rhy", -1, {9'b0, bus.rhy_slot}, 10'h000);
    rst = 1'b0;

    // not yet synced: all slots pass through even with rhythm enabled
    for (int k = 0; k < 18; k++) begin
      r = $urandom;
      drive_slot(1'b0, 10'h155, 1'b1, r[0], 10'h155, 1'b0, k);
    end

    // table-driven frames
    for (int i = 0; i < 9; i++) run_part(ftab[i], 0, 17);

    // reset at slot 15 mid-frame, then pass-through until the next zero
    run_part(ftab[6], 0, 14);
    rst = 1'b1;
    drive_slot(1'b0, 10'h2AA, 1'b1, 1'b0, 10'h000, 1'b0, 15);
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      r  = $urandom;
      ph = (k == 13) ? 10'h004 : other_ph(k + 40);
      drive_slot(1'b0, ph, 1'b1, r[0], ph, 1'b0, k);
    end
    run_part(ftab[9], 0, 17);

    // spurious zero after 9 slots: rhythm slots move with the new alignment
    run_part(ftab[9], 0, 8);
    run_part(ftab[10], 0, 17);

    // cen low for 5 cycles mid-frame: output and count frozen
    run_part(ftab[11], 0, 10);
    for (int c = 0; c < 5; c++) begin
      r = $urandom;
      bus.cen      = 1'b0;
      bus.zero     = (c == 2);
      bus.phase_in = r[9:0];
      bus.noise    = r[10];
      @(posedge clk);
      #1;
      check("hold_phase", 10, bus.phase_out, other_ph(10));
      check("hold_rhy", 10, {9'b0, bus.rhy_slot}, 10'h000);
    end
    run_part(ftab[11], 11, 17);

    check("scoreboard_drained", -1, 10'(q.size()), 10'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
